// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle RV32I datapath.
// Each instruction is sequenced FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK
// over one shared, ready-handshaked instruction/data bus. The control signals come
// from an external control unit that decodes Instr.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   regWE, dmemWE     register-file write enable; store select
//   rs1sel, rs2sel    ALU operand selects (A reg / PC, B reg / ExtImm)
//   regsel            writeback source: 00 MDR, 01 ALUOut, 10 ExtImm, 11 PC+4
//   PCsel             next PC: 00 PC+4, 01 ALUOut & ~1, 10 PC+ExtImm, 11 hold
//   ImmSel            immediate format: 000 I, 001 S, 010 B, 011 U, 100 J
//   ALUControl        0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu,
//                     0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and, 1111 pass B
//   dmemMode          load/store size and sign, forwarded on mem_mode
//   mem_*             shared memory bus (req/we/addr/wdata/mode out, ready/rdata in)
//   Instr             current instruction register
//   ALUResults        combinational ALU output
//   instr_done        one-cycle pulse after each completed WRITEBACK
//   halted            PC frozen by PCsel == 11
//   fault, fault_code sticky fault: 01 misaligned fetch, 10 bus timeout
// XLEN must be at least 32.
module mc_datapath #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            regWE,
    input  logic            dmemWE,
    input  logic            rs1sel,
    input  logic            rs2sel,
    input  logic [1:0]      regsel,
    input  logic [1:0]      PCsel,
    input  logic [2:0]      ImmSel,
    input  logic [3:0]      ALUControl,
    input  logic [2:0]      dmemMode,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_mode,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] ALUResults,
    output logic            instr_done,
    output logic            halted,
    output logic            fault,
    output logic [1:0]      fault_code
);

    localparam logic [31:0]  NOP         = 32'h0000_0013;
    localparam int unsigned  SHAMT_W     = $clog2(XLEN);
    localparam int unsigned  TIMER_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam bit           TIMEOUT_EN  = (TIMEOUT != 0);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_FAULT
    } state_t;

    state_t             state;
    logic [XLEN-1:0]    pc;
    logic [31:0]        ir;
    logic [XLEN-1:0]    a_reg;
    logic [XLEN-1:0]    b_reg;
    logic [XLEN-1:0]    alu_out;
    logic [XLEN-1:0]    mdr;
    logic [TIMER_W-1:0] timer;
    logic [XLEN-1:0]    rf [32];

    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [31:0]        imm32;
    logic [XLEN-1:0]    ext_imm;
    logic [XLEN-1:0]    op_a;
    logic [XLEN-1:0]    op_b;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    next_pc;
    logic [XLEN-1:0]    wb_data;
    logic               bus_done;
    logic               bus_expire;

    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign rd  = ir[11:7];

    assign Instr      = ir;
    assign mem_wdata  = b_reg;
    assign ALUResults = alu_result;

    // Immediate extraction, sign-extended to XLEN
    always_comb begin
        imm32 = '0;
        case (ImmSel)
            3'b000:  imm32 = {{20{ir[31]}}, ir[31:20]};
            3'b001:  imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            3'b010:  imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            3'b011:  imm32 = {ir[31:12], 12'b0};
            3'b100:  imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign ext_imm = XLEN'($signed(imm32));

    // ALU with operand muxes
    always_comb begin
        op_a       = rs1sel ? pc : a_reg;
        op_b       = rs2sel ? ext_imm : b_reg;
        shamt      = op_b[SHAMT_W-1:0];
        alu_result = '0;
        case (ALUControl)
            4'b0000: alu_result = op_a + op_b;
            4'b1000: alu_result = op_a - op_b;
            4'b0001: alu_result = op_a << shamt;
            4'b0010: alu_result = XLEN'($signed(op_a) < $signed(op_b));
            4'b0011: alu_result = XLEN'(op_a < op_b);
            4'b0100: alu_result = op_a ^ op_b;
            4'b0101: alu_result = op_a >> shamt;
            4'b1101: alu_result = $unsigned($signed(op_a) >>> shamt);
            4'b0110: alu_result = op_a | op_b;
            4'b0111: alu_result = op_a & op_b;
            4'b1111: alu_result = op_b;
            default: alu_result = '0;
        endcase
    end

    // Next PC and writeback source, both relative to the current instruction's PC
    always_comb begin
        pc_plus4 = pc + XLEN'(4);
        next_pc  = pc;
        case (PCsel)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = alu_out & ~XLEN'(1);
            2'b10:   next_pc = pc + ext_imm;
            default: next_pc = pc;
        endcase
        wb_data = mdr;
        case (regsel)
            2'b00:   wb_data = mdr;
            2'b01:   wb_data = alu_out;
            2'b10:   wb_data = ext_imm;
            default: wb_data = pc_plus4;
        endcase
    end

    // Ready wins over an expiring timer in the same cycle
    assign bus_done   = mem_req && mem_ready;
    assign bus_expire = TIMEOUT_EN && mem_req && !mem_ready && (timer == TIMER_LAST);

    // Sequencer, datapath registers and register file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= NOP;
            a_reg      <= '0;
            b_reg      <= '0;
            alu_out    <= '0;
            mdr        <= '0;
            timer      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_mode   <= 3'b000;
            instr_done <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            instr_done <= 1'b0;

            if (bus_done) begin
                timer <= '0;
            end else if (TIMEOUT_EN && mem_req) begin
                timer <= timer + TIMER_W'(1);
            end

            case (state)
                S_FETCH: begin
                    if (pc[1:0] != 2'b00) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= 2'b01;
                        mem_req    <= 1'b0;
                    end else if (!mem_req) begin
                        // Only reached right after reset; later fetches are issued from WRITEBACK
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        mem_mode <= 3'b010;
                    end else if (bus_done) begin
                        ir      <= mem_rdata[31:0];
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end else if (bus_expire) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= 2'b10;
                        mem_req    <= 1'b0;
                    end
                end

                S_DECODE: begin
                    a_reg <= (rs1 == 5'd0) ? '0 : rf[rs1];
                    b_reg <= (rs2 == 5'd0) ? '0 : rf[rs2];
                    state <= S_EXECUTE;
                end

                S_EXECUTE: begin
                    alu_out <= alu_result;
                    if (dmemWE || regsel == 2'b00) begin
                        mem_req  <= 1'b1;
                        mem_we   <= dmemWE;
                        mem_addr <= alu_result;
                        mem_mode <= dmemMode;
                        state    <= S_MEMORY;
                    end else begin
                        state <= S_WRITEBACK;
                    end
                end

                S_MEMORY: begin
                    if (bus_done) begin
                        if (!mem_we) begin
                            mdr <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= S_WRITEBACK;
                    end else if (bus_expire) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= 2'b10;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                    end
                end

                S_WRITEBACK: begin
                    if (regWE && rd != 5'd0) begin
                        rf[rd] <= wb_data;
                    end
                    pc         <= next_pc;
                    halted     <= (PCsel == 2'b11);
                    instr_done <= 1'b1;
                    state      <= S_FETCH;
                    // A misaligned target never raises a request; FETCH faults on it
                    if (next_pc[1:0] == 2'b00) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= next_pc;
                        mem_mode <= 3'b010;
                    end
                end

                S_FAULT: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end

                default: begin
                    state   <= S_FAULT;
                    fault   <= 1'b1;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed self-checking bench for mc_datapath.
// A small bus responder with per-region wait states supplies instructions and data.
module tb_mc_datapath;

    localparam int unsigned XLEN   = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        regWE, dmemWE, rs1sel, rs2sel;
    logic [1:0]  regsel, PCsel;
    logic [2:0]  ImmSel, dmemMode;
    logic [3:0]  ALUControl;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_mode;
    logic [31:0] Instr, ALUResults;
    logic        instr_done, halted, fault;
    logic [1:0]  fault_code;

    mc_datapath #(.XLEN(XLEN), .RESET_PC(RST_PC), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .regWE      (regWE),
        .dmemWE     (dmemWE),
        .rs1sel     (rs1sel),
        .rs2sel     (rs2sel),
        .regsel     (regsel),
        .PCsel      (PCsel),
        .ImmSel     (ImmSel),
        .ALUControl (ALUControl),
        .dmemMode   (dmemMode),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mode   (mem_mode),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .Instr      (Instr),
        .ALUResults (ALUResults),
        .instr_done (instr_done),
        .halted     (halted),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    // Bus responder: addresses >= 0x100 are code, below are data
    logic [31:0] mem [0:1023];
    int unsigned fetch_waits = 0;
    int unsigned data_waits  = 0;
    int unsigned wait_cnt    = 0;
    bit          stall_data  = 1'b0;
    bit          spurious    = 1'b0;
    int unsigned store_cnt   = 0;
    int unsigned fetch100    = 0;

    always_comb begin
        mem_rdata = mem[mem_addr[9:0]];
        mem_ready = spurious;
        if (mem_req) begin
            if (mem_addr >= 32'h100) begin
                mem_ready = mem_ready | (wait_cnt >= fetch_waits);
            end else begin
                mem_ready = mem_ready | (!stall_data && wait_cnt >= data_waits);
            end
        end
    end

    always @(posedge clk) begin
        if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
        if (mem_req && mem_ready && mem_we) store_cnt <= store_cnt + 1;
        if (mem_req && mem_ready && !mem_we && mem_addr == 32'h100) fetch100 <= fetch100 + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!instr_done && cyc < max_cyc);
    endtask

    task automatic set_ctrl(input logic we, input logic dwe, input logic r1, input logic r2,
                            input logic [1:0] rsel, input logic [1:0] psel,
                            input logic [2:0] imm, input logic [3:0] alu, input logic [2:0] dmode);
        regWE = we; dmemWE = dwe; rs1sel = r1; rs2sel = r2;
        regsel = rsel; PCsel = psel; ImmSel = imm; ALUControl = alu; dmemMode = dmode;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int unsigned base;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hFFFF_FFFF;
        mem[10'h100] = 32'h0050_0093;   // addi x1,x0,5
        mem[10'h104] = 32'h0000_A103;   // lw   x2,0(x1)
        mem[10'h108] = 32'h2030_0193;   // addi x3,x0,0x203
        mem[10'h10C] = 32'h0001_80E7;   // jalr x1,0(x3)
        mem[10'h005] = 32'hDEAD_BEEF;

        // Reset state
        set_ctrl(1, 0, 0, 1, 2'b01, 2'b00, 3'b000, 4'b0000, 3'b010);
        reset = 1'b1;
        repeat (2) tick();
        check("rst_req",   64'(mem_req), 64'd0);
        check("rst_addr",  64'(mem_addr), 64'd0);
        check("rst_instr", 64'(Instr), 64'(NOP));
        check("rst_flags", 64'({fault, fault_code, halted, instr_done}), 64'd0);

        // First fetch; a ready while no request is outstanding must be ignored
        spurious = 1'b1;
        reset    = 1'b0;
        tick();
        spurious = 1'b0;
        check("fetch0_instr", 64'(Instr), 64'(NOP));
        check("fetch0_bus", 64'({mem_req, mem_we, mem_mode, mem_addr}), 64'({1'b1, 1'b0, 3'b010, 32'h100}));

        // addi x1,x0,5
        wait_done(20, cyc);
        check("addi_cycles", 64'(cyc), 64'd4);
        check("addi_x1", 64'(dut.rf[1]), 64'd5);
        check("addi_next", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h104}));

        // lw x2,0(x1) with three data wait states
        set_ctrl(1, 0, 0, 1, 2'b00, 2'b00, 3'b000, 4'b0000, 3'b010);
        data_waits = 3;
        tick();
        check("done_pulse", 64'(instr_done), 64'd0);
        tick();
        check("lw_alu", 64'(ALUResults), 64'd5);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lw_bus", 64'({mem_req, mem_we, mem_mode, mem_addr}), 64'({1'b1, 1'b0, 3'b010, 32'h5}));
        end
        wait_done(20, cyc);
        check("lw_cycles", 64'(cyc + 6), 64'd8);
        check("lw_x2", 64'(dut.rf[2]), 64'hDEAD_BEEF);
        check("lw_next", 64'(mem_addr), 64'h108);

        // addi x3,x0,0x203
        set_ctrl(1, 0, 0, 1, 2'b01, 2'b00, 3'b000, 4'b0000, 3'b010);
        wait_done(20, cyc);
        check("addi3_cycles", 64'(cyc), 64'd4);
        check("addi3_x3", 64'(dut.rf[3]), 64'h203);

        // jalr x1,0(x3): target 0x202 is misaligned
        set_ctrl(1, 0, 0, 1, 2'b11, 2'b01, 3'b000, 4'b0000, 3'b010);
        wait_done(20, cyc);
        check("jalr_cycles", 64'(cyc), 64'd4);
        check("jalr_link", 64'(dut.rf[1]), 64'h110);
        check("jalr_pc", 64'(dut.pc), 64'h202);
        check("jalr_noreq", 64'(mem_req), 64'd0);
        tick();
        check("misalign_fault", 64'({fault, fault_code, mem_req}), 64'({1'b1, 2'b01, 1'b0}));
        repeat (3) tick();
        check("fault_sticky", 64'({fault, fault_code, mem_req}), 64'({1'b1, 2'b01, 1'b0}));

        // Halt: PCsel=11 twice, then 00
        reset = 1'b1;
        #1;
        check("rst2_fault", 64'({fault, fault_code}), 64'd0);
        mem[10'h104] = 32'h0010_2423;   // sw x1,8(x0)
        set_ctrl(1, 0, 0, 1, 2'b01, 2'b11, 3'b000, 4'b0000, 3'b010);
        tick();
        base  = fetch100;
        reset = 1'b0;
        tick();
        check("halt_start", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h100}));
        wait_done(20, cyc);
        check("halt1", 64'({halted, mem_addr}), 64'({1'b1, 32'h100}));
        wait_done(20, cyc);
        check("halt2", 64'({halted, mem_addr}), 64'({1'b1, 32'h100}));
        PCsel = 2'b00;
        wait_done(20, cyc);
        check("halt_release", 64'({halted, mem_addr}), 64'({1'b0, 32'h104}));
        check("halt_refetch", 64'(fetch100 - base), 64'd3);

        // sw x1,8(x0) with the data bus stalled: timeout after 16 waiting cycles
        set_ctrl(1, 1, 0, 1, 2'b01, 2'b00, 3'b001, 4'b0000, 3'b010);
        stall_data = 1'b1;
        base = store_cnt;
        repeat (3) tick();
        check("sw_bus", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b1, 32'h8}));
        check("sw_wdata", 64'(mem_wdata), 64'd5);
        cyc = 0;
        while (!fault && cyc < 40) begin
            tick();
            cyc++;
        end
        check("to_cycles", 64'(cyc), 64'd16);
        check("to_fault", 64'({fault, fault_code, mem_req}), 64'({1'b1, 2'b10, 1'b0}));
        check("to_nowrite", 64'(dut.rf[8]), 64'd0);
        check("to_nostore", 64'(store_cnt - base), 64'd0);

        // Reset clears the fault and restarts at RESET_PC
        reset = 1'b1;
        #1;
        check("rst3_flags", 64'({fault, fault_code, mem_req, halted, instr_done}), 64'd0);
        check("rst3_instr", 64'(Instr), 64'(NOP));
        stall_data = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("restart", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h100}));

        // Reset mid-access drops the request without waiting for a clock edge
        #2;
        reset = 1'b1;
        #1;
        check("async_drop", 64'(mem_req), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
Parametrised multi-cycle successor to the single-cycle RV32I datapath. It keeps the same external control-signal set, sequences each instruction through a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine, and talks to one shared instruction/data memory over a ready-handshaked bus, so wait-state memories are supported. It adds latched pipeline registers (IR, A, B, ALUOut, MDR), a halt mode, a bus timeout and a sticky fault state.

Parameters:
XLEN, 32, datapath and address width; must be ≥32.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, max cycles mem_req may wait for mem_ready before fault; 0 disables the timeout.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
regWE  in  1  register-file write enable, sampled in WRITEBACK
dmemWE  in  1  1 = store; selects the store path in MEMORY
rs1sel  in  1  ALU A: 0 = A reg, 1 = PC
rs2sel  in  1  ALU B: 0 = B reg, 1 = ExtImm
regsel  in  2  WB source: 00 MDR, 01 ALUOut, 10 ExtImm, 11 PC+4
PCsel  in  2  next PC: 00 PC+4, 01 ALUOut & ~1, 10 PC+ExtImm, 11 hold (halt)
ImmSel  in  3  immediate format for the extend unit
ALUControl  in  4  ALU operation code
dmemMode  in  3  load/store size and sign, forwarded to mem_mode
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_addr  out  XLEN  bus address
mem_wdata  out  XLEN  store data (B reg)
mem_mode  out  3  access size: 3'b010 (word) in FETCH, dmemMode in MEMORY
mem_ready  in  1  bus completion
mem_rdata  in  XLEN  read data
Instr  out  32  current IR (drives the control unit)
ALUResults  out  XLEN  combinational ALU output
instr_done  out  1  one-cycle pulse when WRITEBACK completes
halted  out  1  high while PCsel==11 has frozen the PC
fault  out  1  sticky fault flag
fault_code  out  2  01 misaligned fetch, 10 bus timeout, 00 none

Behaviour:
- Reset (async): state=FETCH; PC=RESET_PC; IR=32'h0000_0013 (NOP); A, B, ALUOut, MDR, timer = 0; all outputs 0 except Instr=NOP.
- FETCH: if PC[1:0]!=0, go to FAULT with code 01 and assert no request. Otherwise drive mem_req=1, mem_we=0, mem_addr=PC. Hold all request outputs stable until mem_ready. On the mem_ready edge, IR<=mem_rdata and go to DECODE.
- DECODE (1 cycle): A<=rf[IR[19:15]], B<=rf[IR[24:20]]. x0 always reads 0.
- EXECUTE (1 cycle): ALUOut<=ALU(muxA, muxB). Next state is MEMORY if dmemWE=1 or regsel=00, else WRITEBACK.
- MEMORY: mem_req=1, mem_addr=ALUOut, mem_we=dmemWE, mem_mode=dmemMode. On mem_ready, MDR<=mem_rdata (loads) and go to WRITEBACK.
- WRITEBACK (1 cycle):
  - If regWE and rd!=0, write the selected source to rf[rd].
  - PC updates per PCsel; PC+4 and PC+Imm use the instruction's PC, wrapping mod 2^XLEN.
  - Pulse instr_done, then go to FETCH.
- Halt: PCsel=11 leaves PC unchanged and sets halted=1. The same instruction then refetches and re-executes; halted clears in the first WRITEBACK with PCsel!=11.
- Latency: 4 cycles per non-memory instruction, 5 per load/store, plus memory wait states (zero-wait mem_ready is allowed).
- Timeout:
  - The timer counts cycles with mem_req=1 and mem_ready=0, and clears when a request completes.
  - If it reaches TIMEOUT, go to FAULT with code 10 and drop mem_req the next cycle.
- FAULT: absorbing; mem_req=0, no register/PC writes, fault=1. Exit only via reset.
- Simultaneous events: mem_ready arriving in the same cycle the timer reaches TIMEOUT counts as success. A mem_ready asserted while mem_req=0 is ignored.
- Reset mid-access: the request is abandoned immediately (mem_req drops asynchronously) and no partial write occurs.

Test Plan:
- Reset, RESET_PC=0x100, zero-wait memory -> first mem_addr=0x100, Instr=NOP before the first fetch completes.
- addi x1,x0,5 (0x00500093), zero-wait -> x1=5 after 4 cycles; instr_done pulses once; next fetch at 0x104.
- lw x2,0(x1) with 3 wait states, mem[5]=0xDEADBEEF -> x2=0xDEADBEEF; request outputs stable across waits; 5+3 cycles after the fetch completes.
- jalr x1,0(x3) with x3=0x203, PCsel=01 -> PC=0x202 is misaligned -> next FETCH raises fault, fault_code=01, mem_req stays 0.
- TIMEOUT=16, mem_ready held low during a store -> fault=1, fault_code=10 on cycle 16, no register write; reset clears the fault and restarts at RESET_PC.
- PCsel=11 for two instructions, then 00 -> same PC fetched three times, halted high then low, PC advances by 4.
